halt_dump_unit: RTL and testbench

CPU-side halt and state-dump controller: the hardware end of the simulation harness's halt/register-dump interface. It counts elapsed cycles, detects the halt condition, freezes the pipeline once in-flight instructions drain, and streams a cycle-count word plus all 32 architectural registers out over a valid/ready port. It asserts `is_halted` only after the last word is accepted. It sits in the CPU next to the register file and reads it through a dedicated read port.

---
 rtl/halt_dump_unit_if.sv | 24 ++
 rtl/halt_dump_unit.sv | 108 ++++++++++
 tb/tb_halt_dump_unit.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/halt_dump_unit_if.sv
// Dump stream port of the halt/dump controller: one word per valid/ready handshake.
interface halt_dump_unit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = 6
);
  logic                  dump_valid;
  logic                  dump_ready;
  logic [IDX_WIDTH-1:0]  dump_idx;
  logic [DATA_WIDTH-1:0] dump_data;

  modport master (
    output dump_valid,
    output dump_idx,
    output dump_data,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_idx,
    input  dump_data,
    output dump_ready
  );
endinterface

// File: rtl/halt_dump_unit.sv
// Halt detection, pipeline drain/freeze and register-file dump over a valid/ready stream.
// Word 0 carries the cycle-count snapshot; word k carries register x(k-1).
module halt_dump_unit #(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  halt_req,
  input  logic                  pipe_empty,
  output logic                  freeze,
  output logic [4:0]            rf_rd_addr,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  halt_dump_unit_if.master      dump,
  output logic [DATA_WIDTH-1:0] total_cycle,
  output logic                  is_halted
);

  typedef enum logic [1:0] {StRun, StDrain, StDump, StDone} state_e;

  localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(NUM_REGS);

  state_e                state_q;
  logic                  freeze_q;
  logic                  valid_q;
  logic                  halted_q;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic [DATA_WIDTH-1:0] cycle_q;
  logic [DATA_WIDTH-1:0] snap_q;

  logic handshake;
  logic last_word;

  assign handshake = valid_q & dump.dump_ready;
  assign last_word = (idx_q == LastIdx);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StRun;
      freeze_q <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      idx_q    <= '0;
      cycle_q  <= '0;
      snap_q   <= '0;
    end else begin
      // Time stops once the dump begins so the snapshot and live count agree.
      if (state_q == StRun || state_q == StDrain) begin
        cycle_q <= cycle_q + DATA_WIDTH'(1);
      end
      unique case (state_q)
        StRun: begin
          if (halt_req) begin
            state_q  <= StDrain;
            freeze_q <= 1'b1;
          end
        end
        StDrain: begin
          // pipe_empty is only sampled here, so DRAIN always lasts at least one cycle.
          if (pipe_empty) begin
            state_q <= StDump;
            valid_q <= 1'b1;
            idx_q   <= '0;
            snap_q  <= cycle_q + DATA_WIDTH'(1);
          end
        end
        StDump: begin
          if (handshake) begin
            if (last_word) begin
              state_q  <= StDone;
              valid_q  <= 1'b0;
              halted_q <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_WIDTH'(1);
            end
          end
        end
        StDone: begin
          state_q <= StDone;
        end
        default: begin
          state_q <= StRun;
        end
      endcase
    end
  end

  assign freeze      = freeze_q;
  assign is_halted   = halted_q;
  assign total_cycle = cycle_q;

  // The register file is frozen during the dump, so its combinational read data is stable.
  assign rf_rd_addr = (idx_q == '0) ? 5'd0 : 5'(idx_q - IDX_WIDTH'(1));

  assign dump.dump_valid = valid_q;
  assign dump.dump_idx   = idx_q;
  assign dump.dump_data  = !valid_q      ? '0 :
                           (idx_q == '0) ? snap_q : rf_rd_data;

  // A presented word keeps its index until the consumer takes it.
  assert property (@(posedge clk) disable iff (!reset)
    (valid_q && !dump.dump_ready) |=> (valid_q && $stable(idx_q)));

  assert property (@(posedge clk) disable iff (!reset)
    halted_q |=> halted_q);

endmodule

// File: tb/tb_halt_dump_unit.sv
// Scoreboard bench for halt_dump_unit: stimulus queues expected dump words, a monitor checks them.
module tb_halt_dump_unit;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] data;
  } word_t;

  logic        clk;
  logic        reset;
  logic        halt_req;
  logic        pipe_empty;
  logic        freeze;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic [31:0] total_cycle;
  logic        is_halted;

  logic        reset_s;
  logic        halt_req_s;
  logic        pipe_empty_s;
  logic        freeze_s;
  logic [4:0]  rf_rd_addr_s;
  logic [7:0]  rf_rd_data_s;
  logic [7:0]  total_cycle_s;
  logic        is_halted_s;

  logic [31:0] regs [32];
  word_t       exp_q [$];
  int          n_vec;
  int          n_err;
  int          hs_count;
  int          last_hs_cyc;
  int          cyc;

  halt_dump_unit_if #(.DATA_WIDTH(32), .IDX_WIDTH(6)) dif ();
  halt_dump_unit_if #(.DATA_WIDTH(8),  .IDX_WIDTH(6)) dif_s ();

  halt_dump_unit #(.NUM_REGS(32), .DATA_WIDTH(32), .IDX_WIDTH(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .halt_req    (halt_req),
    .pipe_empty  (pipe_empty),
    .freeze      (freeze),
    .rf_rd_addr  (rf_rd_addr),
    .rf_rd_data  (rf_rd_data),
    .dump        (dif),
    .total_cycle (total_cycle),
    .is_halted   (is_halted)
  );

  // Narrow counter instance so the wrap-around is reachable in a few hundred cycles.
  halt_dump_unit #(.NUM_REGS(32), .DATA_WIDTH(8), .IDX_WIDTH(6)) dut_small (
    .clk         (clk),
    .reset       (reset_s),
    .halt_req    (halt_req_s),
    .pipe_empty  (pipe_empty_s),
    .freeze      (freeze_s),
    .rf_rd_addr  (rf_rd_addr_s),
    .rf_rd_data  (rf_rd_data_s),
    .dump        (dif_s),
    .total_cycle (total_cycle_s),
    .is_halted   (is_halted_s)
  );

  assign rf_rd_data = regs[rf_rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented word must match the head of the queue; a handshake pops it.
  always @(negedge clk) begin
    if (reset && dif.dump_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got idx %0d data 0x%0h, required no word",
                 dif.dump_idx, dif.dump_data);
      end else begin
        check("dump_word", 64'({dif.dump_idx, dif.dump_data}), 64'(exp_q[0]));
        if (dif.dump_ready) begin
          void'(exp_q.pop_front());
          hs_count++;
          last_hs_cyc = cyc;
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_freeze",      64'(freeze),         64'(0));
    check("rst_dump_valid",  64'(dif.dump_valid), 64'(0));
    check("rst_dump_idx",    64'(dif.dump_idx),   64'(0));
    check("rst_dump_data",   64'(dif.dump_data),  64'(0));
    check("rst_rf_rd_addr",  64'(rf_rd_addr),     64'(0));
    check("rst_total_cycle", 64'(total_cycle),    64'(0));
    check("rst_is_halted",   64'(is_halted),      64'(0));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    check_reset_outputs();
    exp_q.delete();
    reset = 1'b1;
  endtask

  // Halt when total_cycle == h, drain for d cycles; snapshot is h + 1 + d.
  task automatic run_dump(input logic [31:0] h, input int d, input bit bp, input int abort_idx);
    logic [31:0] snap;
    int          n;
    snap       = h + 32'(d) + 32'd1;
    dif.dump_ready = 1'b1;
    pipe_empty = 1'b1;
    n = 0;
    while (total_cycle != h && n < 1000) begin
      tick();
      n++;
    end
    check("reach_halt_point", 64'(total_cycle), 64'(h));
    exp_q.delete();
    hs_count = 0;
    for (int k = 0; k <= 32; k++) begin
      exp_q.push_back('{idx: 6'(k), data: (k == 0) ? snap : regs[k-1]});
    end
    if (d > 1) pipe_empty = 1'b0;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("freeze_after_halt", 64'(freeze),         64'(1));
    check("drain_no_valid",    64'(dif.dump_valid), 64'(0));
    for (int i = 1; i < d; i++) begin
      tick();
      check("drain_hold", 64'({freeze, dif.dump_valid}), 64'(2'b10));
    end
    pipe_empty = 1'b1;
    tick();
    check("dump_start_valid", 64'(dif.dump_valid), 64'(1));
    check("dump_start_idx",   64'(dif.dump_idx),   64'(0));
    check("snapshot_total",   64'(total_cycle),    64'(snap));
    n = 0;
    while (!is_halted && n < 400) begin
      if (abort_idx >= 0 && int'(dif.dump_idx) == abort_idx + 1) break;
      dif.dump_ready = bp ? ((n % 3) == 0) : 1'b1;
      tick();
      n++;
    end
    if (abort_idx >= 0) begin
      check("abort_point", 64'(dif.dump_idx), 64'(abort_idx + 1));
    end else begin
      check("is_halted_set",     64'(is_halted),        64'(1));
      check("halt_after_last",   64'(cyc),              64'(last_hs_cyc + 1));
      check("handshake_count",   64'(hs_count),         64'(33));
      check("queue_drained",     64'(exp_q.size()),     64'(0));
      check("done_valid_low",    64'(dif.dump_valid),   64'(0));
      check("done_freeze",       64'(freeze),           64'(1));
      check("total_frozen",      64'(total_cycle),      64'(snap));
      if (!bp) check("dump_cycles", 64'(n), 64'(33));
    end
    dif.dump_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_vec          = 0;
    n_err          = 0;
    hs_count       = 0;
    last_hs_cyc    = 0;
    reset          = 1'b0;
    halt_req       = 1'b0;
    pipe_empty     = 1'b1;
    dif.dump_ready = 1'b1;
    reset_s        = 1'b0;
    halt_req_s     = 1'b0;
    pipe_empty_s   = 1'b1;
    rf_rd_data_s   = 8'h00;
    dif_s.dump_ready = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + 32'(i);

    // Reset held three cycles, then the counter starts at 1.
    repeat (3) begin
      tick();
      check_reset_outputs();
    end
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("count_after_reset", 64'(total_cycle), 64'(i));
    end

    // Basic dump, then a halt request in DONE must be ignored.
    run_dump(32'd100, 1, 1'b0, -1);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    repeat (4) begin
      tick();
      check("done_ignores_halt", 64'({freeze, dif.dump_valid, is_halted}), 64'(3'b101));
      check("done_total_held",   64'(total_cycle), 64'(102));
    end

    // Backpressure with a 1,0,0 ready pattern.
    do_reset();
    for (int i = 0; i < 32; i++) regs[i] = 32'hA5A5_0000 ^ (32'(i) << 4);
    run_dump(32'd20, 1, 1'b1, -1);

    // Pipeline takes five cycles to drain.
    do_reset();
    run_dump(32'd40, 5, 1'b0, -1);

    // Reset after the handshake at index 10, then a full dump from index 0.
    do_reset();
    run_dump(32'd30, 1, 1'b0, 10);
    do_reset();
    for (int i = 0; i < 32; i++) regs[i] = 32'hCAFE_0000 | 32'(31 - i);
    run_dump(32'd15, 1, 1'b0, -1);

    // Counter wrap on the narrow instance.
    reset_s = 1'b1;
    n = 0;
    while (total_cycle_s != 8'hFE && n < 300) begin
      tick();
      n++;
    end
    check("wrap_reach_fe", 64'(total_cycle_s), 64'(8'hFE));
    tick();
    check("wrap_ff", 64'(total_cycle_s), 64'(8'hFF));
    tick();
    check("wrap_00", 64'(total_cycle_s), 64'(8'h00));
    tick();
    check("wrap_01", 64'(total_cycle_s), 64'(8'h01));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
